// File: rtl/cfg_serial_tx.sv
// cfg_serial_tx: holds the backend in reset after power-up, then shifts one start-bit-prefixed
// configuration frame out on o_sclk/o_sdout per request and waits for the backend's acknowledge.
module cfg_serial_tx #(
    parameter int FRAME_W     = 5,
    parameter int SCLK_DIV    = 4,
    parameter int RESET_HOLD  = 16,
    parameter int ACK_TIMEOUT = 256
) (
    input  logic               i_mainclk,
    input  logic               i_resetbFPGA,
    input  logic               i_start,
    input  logic [FRAME_W-1:0] i_data,
    input  logic               i_ready,
    output logic               o_resetbAll,
    output logic               o_sclk,
    output logic               o_sdout,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err
);
    localparam int BW = $clog2(FRAME_W + 2);
    localparam int DW = $clog2(SCLK_DIV + 1);
    localparam int HW = $clog2(RESET_HOLD + 1);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {HOLD, IDLE, SHIFT, WAIT_ACK} state_t;

    state_t           r_state;
    logic             r_rdy_meta;
    logic             r_rdy_sync;
    logic [FRAME_W:0] r_sh;
    logic [BW-1:0]    r_bit;
    logic [DW-1:0]    r_div;
    logic [HW-1:0]    r_hold;
    logic [TW-1:0]    r_to;

    always_ff @(posedge i_mainclk or negedge i_resetbFPGA) begin
        if (!i_resetbFPGA) begin
            r_rdy_meta <= 1'b0;
            r_rdy_sync <= 1'b0;
        end else begin
            r_rdy_meta <= i_ready;
            r_rdy_sync <= r_rdy_meta;
        end
    end

    always_ff @(posedge i_mainclk or negedge i_resetbFPGA) begin
        if (!i_resetbFPGA) begin
            r_state     <= HOLD;
            r_sh        <= '0;
            r_bit       <= '0;
            r_div       <= '0;
            r_hold      <= '0;
            r_to        <= '0;
            o_resetbAll <= 1'b0;
            o_sclk      <= 1'b0;
            o_sdout     <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            o_done <= 1'b0;
            o_err  <= 1'b0;
            case (r_state)
                HOLD: begin
                    o_busy <= 1'b1;
                    if (r_hold == HW'(RESET_HOLD - 1)) begin
                        o_resetbAll <= 1'b1;
                        o_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end else begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
                IDLE: begin
                    if (i_start) begin
                        r_sh    <= {1'b1, i_data};
                        o_sdout <= 1'b1;
                        o_busy  <= 1'b1;
                        r_div   <= '0;
                        r_bit   <= '0;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (r_div != DW'(SCLK_DIV - 1)) begin
                        r_div <= r_div + 1'b1;
                    end else begin
                        r_div <= '0;
                        if (!o_sclk) begin
                            o_sclk <= 1'b1;
                        end else if (r_bit == BW'(FRAME_W)) begin
                            o_sclk  <= 1'b0;
                            o_sdout <= 1'b0;
                            r_to    <= '0;
                            r_state <= WAIT_ACK;
                        end else begin
                            // next bit is launched together with the falling edge of o_sclk
                            o_sclk  <= 1'b0;
                            o_sdout <= r_sh[FRAME_W-1];
                            r_sh    <= {r_sh[FRAME_W-1:0], 1'b0};
                            r_bit   <= r_bit + 1'b1;
                        end
                    end
                end
                WAIT_ACK: begin
                    if (r_rdy_sync) begin
                        o_done  <= 1'b1;
                        o_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (r_to == TW'(ACK_TIMEOUT - 1)) begin
                        o_err   <= 1'b1;
                        o_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_to <= r_to + 1'b1;
                    end
                end
                default: r_state <= HOLD;
            endcase
        end
    end
endmodule

// File: tb/tb_cfg_serial_tx.sv
// tb_cfg_serial_tx: directed scenario bench for cfg_serial_tx (FRAME_W=5, SCLK_DIV=2, RESET_HOLD=16, ACK_TIMEOUT=256).
module tb_cfg_serial_tx;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_start = 1'b0;
    logic [4:0] i_data = '0;
    logic       i_ready = 1'b0;
    logic       o_resetbAll, o_sclk, o_sdout, o_busy, o_done, o_err;

    int chk_cnt = 0;
    int pass_cnt = 0;

    logic [7:0] cap_bits;
    int cap_rise, cap_first_hi, cap_last_hi, cap_done_at, cap_err_at;
    int cap_ndone, cap_nerr, cap_both, cap_glitch;
    logic cap_sd1, cap_sclk_at_done;

    cfg_serial_tx #(.FRAME_W(5), .SCLK_DIV(2), .RESET_HOLD(16), .ACK_TIMEOUT(256)) dut (
        .i_mainclk(clk), .i_resetbFPGA(rst_n), .i_start(i_start), .i_data(i_data), .i_ready(i_ready),
        .o_resetbAll(o_resetbAll), .o_sclk(o_sclk), .o_sdout(o_sdout), .o_busy(o_busy),
        .o_done(o_done), .o_err(o_err)
    );

    always #5 clk = ~clk;

    // Requests one frame and records what appears on the outputs for up to max_n negedges.
    // Negedge n follows the n-th rising edge after the one that samples i_start.
    task automatic frame(input logic [4:0] d, input int max_n, input bit stop_done,
                         input int inj_at, input logic [4:0] inj_d);
        logic prev_sclk, prev_sd;
        @(negedge clk);
        i_data = d;
        i_start = 1'b1;
        prev_sclk = 1'b0;
        prev_sd = 1'b0;
        cap_bits = '0; cap_rise = 0; cap_first_hi = -1; cap_last_hi = -1;
        cap_done_at = -1; cap_err_at = -1; cap_ndone = 0; cap_nerr = 0;
        cap_both = 0; cap_glitch = 0; cap_sd1 = 1'b0; cap_sclk_at_done = 1'b1;
        for (int n = 1; n <= max_n; n++) begin
            @(negedge clk);
            if (n == 1) begin
                i_start = 1'b0;
                i_data = ~d;
                cap_sd1 = o_sdout;
            end
            if (n == inj_at) begin
                i_start = 1'b1;
                i_data = inj_d;
            end
            if (n == inj_at + 1) i_start = 1'b0;
            if (o_sclk && !prev_sclk) begin
                cap_bits = {cap_bits[6:0], o_sdout};
                cap_rise++;
            end
            if (o_sclk && prev_sclk && o_sdout !== prev_sd) cap_glitch++;
            if (o_sclk) begin
                if (cap_first_hi < 0) cap_first_hi = n;
                cap_last_hi = n;
            end
            if (o_done) begin
                cap_ndone++;
                if (cap_done_at < 0) begin
                    cap_done_at = n;
                    cap_sclk_at_done = o_sclk;
                end
            end
            if (o_err) begin
                cap_nerr++;
                if (cap_err_at < 0) cap_err_at = n;
            end
            if (o_done && o_err) cap_both++;
            prev_sclk = o_sclk;
            prev_sd = o_sdout;
            if (stop_done && o_done) break;
        end
    endtask

    task automatic test_reset();
        int low_cnt, busy_cnt;
        i_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_cnt++;
        if ({o_resetbAll, o_sclk, o_sdout, o_busy, o_done, o_err} !== 6'b0) $display("FAIL reset_outputs: got %b want 000000", {o_resetbAll, o_sclk, o_sdout, o_busy, o_done, o_err});
        else pass_cnt++;
        rst_n = 1'b1;
        low_cnt = 0;
        busy_cnt = 0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (!o_resetbAll) low_cnt++;
            if (o_busy) busy_cnt++;
        end
        chk_cnt++;
        if (low_cnt !== 15) $display("FAIL hold_low_cycles: got %0d want 15", low_cnt);
        else pass_cnt++;
        chk_cnt++;
        if (busy_cnt !== 15) $display("FAIL hold_busy_cycles: got %0d want 15", busy_cnt);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (o_resetbAll !== 1'b1) $display("FAIL hold_release: got %b want 1", o_resetbAll);
        else pass_cnt++;
        chk_cnt++;
        if (o_busy !== 1'b0) $display("FAIL hold_busy_end: got %b want 0", o_busy);
        else pass_cnt++;
    endtask

    task automatic test_frame();
        frame(5'b10110, 40, 1'b0, 0, 5'b0);
        chk_cnt++;
        if (cap_bits[5:0] !== 6'b110110) $display("FAIL frame_bits: got %b want 110110", cap_bits[5:0]);
        else pass_cnt++;
        chk_cnt++;
        if (cap_rise !== 6) $display("FAIL frame_rises: got %0d want 6", cap_rise);
        else pass_cnt++;
        chk_cnt++;
        if (cap_sd1 !== 1'b1) $display("FAIL frame_first_bit: got %b want 1", cap_sd1);
        else pass_cnt++;
        chk_cnt++;
        if (cap_first_hi !== 3) $display("FAIL frame_first_high: got %0d want 3", cap_first_hi);
        else pass_cnt++;
        chk_cnt++;
        if (cap_last_hi !== 24) $display("FAIL frame_shift_len: got %0d want 24", cap_last_hi);
        else pass_cnt++;
        chk_cnt++;
        if (cap_done_at < 25 || cap_done_at > 27) $display("FAIL frame_done_latency: got %0d want 25..27", cap_done_at);
        else pass_cnt++;
        chk_cnt++;
        if (cap_ndone !== 1 || cap_nerr !== 0) $display("FAIL frame_done_count: got done=%0d err=%0d want 1 0", cap_ndone, cap_nerr);
        else pass_cnt++;
        chk_cnt++;
        if (cap_glitch !== 0) $display("FAIL frame_sdout_stable: got %0d changes while sclk high want 0", cap_glitch);
        else pass_cnt++;
        chk_cnt++;
        if ({o_busy, o_sclk, o_sdout} !== 3'b000) $display("FAIL frame_idle_after: got %b want 000", {o_busy, o_sclk, o_sdout});
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        i_ready = 1'b0;
        repeat (4) @(negedge clk);
        frame(5'b00110, 300, 1'b0, 0, 5'b0);
        chk_cnt++;
        if (cap_bits[5:0] !== 6'b100110) $display("FAIL timeout_bits: got %b want 100110", cap_bits[5:0]);
        else pass_cnt++;
        chk_cnt++;
        if (cap_err_at !== 281) $display("FAIL timeout_err_time: got %0d want 281", cap_err_at);
        else pass_cnt++;
        chk_cnt++;
        if (cap_nerr !== 1 || cap_ndone !== 0) $display("FAIL timeout_counts: got err=%0d done=%0d want 1 0", cap_nerr, cap_ndone);
        else pass_cnt++;
        chk_cnt++;
        if (o_busy !== 1'b0) $display("FAIL timeout_idle: got busy=%b want 0", o_busy);
        else pass_cnt++;
        i_ready = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_start_ignored();
        frame(5'b01001, 60, 1'b0, 8, 5'b10110);
        chk_cnt++;
        if (cap_bits[5:0] !== 6'b101001) $display("FAIL midstart_bits: got %b want 101001", cap_bits[5:0]);
        else pass_cnt++;
        chk_cnt++;
        if (cap_rise !== 6) $display("FAIL midstart_rises: got %0d want 6", cap_rise);
        else pass_cnt++;
        chk_cnt++;
        if (cap_ndone !== 1 || cap_both !== 0) $display("FAIL midstart_done: got done=%0d both=%0d want 1 0", cap_ndone, cap_both);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int low_cnt, rises;
        logic prev_sclk;
        @(negedge clk);
        i_data = 5'b11111;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (10) @(negedge clk);
        chk_cnt++;
        if ({o_sclk, o_sdout} !== 2'b11) $display("FAIL rstmid_precond: got %b want 11", {o_sclk, o_sdout});
        else pass_cnt++;
        #1 rst_n = 1'b0;
        #1;
        chk_cnt++;
        if ({o_sclk, o_sdout, o_resetbAll, o_busy} !== 4'b0) $display("FAIL rstmid_async: got %b want 0000", {o_sclk, o_sdout, o_resetbAll, o_busy});
        else pass_cnt++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        low_cnt = 0;
        rises = 0;
        prev_sclk = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (!o_resetbAll) low_cnt++;
            if (o_sclk && !prev_sclk) rises++;
            prev_sclk = o_sclk;
        end
        chk_cnt++;
        if (low_cnt !== 15) $display("FAIL rstmid_hold: got %0d low cycles want 15", low_cnt);
        else pass_cnt++;
        chk_cnt++;
        if (rises !== 0 || o_busy !== 1'b0) $display("FAIL rstmid_no_resume: got rises=%0d busy=%b want 0 0", rises, o_busy);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        frame(5'b00001, 40, 1'b1, 0, 5'b0);
        chk_cnt++;
        if (cap_bits[5:0] !== 6'b100001) $display("FAIL b2b_first_bits: got %b want 100001", cap_bits[5:0]);
        else pass_cnt++;
        chk_cnt++;
        if (cap_done_at < 25 || cap_done_at > 27) $display("FAIL b2b_first_done: got %0d want 25..27", cap_done_at);
        else pass_cnt++;
        chk_cnt++;
        if (cap_sclk_at_done !== 1'b0) $display("FAIL b2b_gap_sclk: got %b want 0", cap_sclk_at_done);
        else pass_cnt++;
        frame(5'b11111, 40, 1'b0, 0, 5'b0);
        chk_cnt++;
        if (cap_bits[5:0] !== 6'b111111) $display("FAIL b2b_second_bits: got %b want 111111", cap_bits[5:0]);
        else pass_cnt++;
        chk_cnt++;
        if (cap_rise !== 6 || cap_ndone !== 1) $display("FAIL b2b_second_counts: got rises=%0d done=%0d want 6 1", cap_rise, cap_ndone);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_frame();
        test_timeout();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/cfg_serial_tx.md
Name: cfg_serial_tx

Overview:
FPGA-side transmitter for the backend configuration link. After FPGA reset it holds the backend in reset (o_resetbAll low) for a fixed time, then releases it. On request it shifts one configuration frame out on o_sclk/o_sdout, then waits for the backend's i_ready acknowledge. It is the synthesizable counterpart of the backend's serial receiver.

Parameters:
FRAME_W, 5, payload bits per frame (default covers gainA1[1:0] followed by gainA2[2:0]).
SCLK_DIV, 4, i_mainclk cycles per o_sclk half-period (must be ≥1).
RESET_HOLD, 16, i_mainclk cycles o_resetbAll is held low after reset release (must be ≥1).
ACK_TIMEOUT, 256, i_mainclk cycles to wait for i_ready after the last bit.

Ports:
i_mainclk  input  1  system clock; all logic is on the rising edge.
i_resetbFPGA  input  1  asynchronous, active-low reset.
i_start  input  1  single-cycle frame request.
i_data  input  FRAME_W  frame payload, sent MSB first.
i_ready  input  1  backend acknowledge, asynchronous to i_mainclk.
o_resetbAll  output  1  active-low reset to the backend.
o_sclk  output  1  serial clock to the backend.
o_sdout  output  1  serial data to the backend.
o_busy  output  1  high in HOLD, SHIFT and WAIT_ACK.
o_done  output  1  one-cycle pulse when the acknowledge is received.
o_err  output  1  one-cycle pulse when the acknowledge times out.

Behaviour:
- Reset (i_resetbFPGA low): all outputs go low asynchronously, including o_resetbAll, and the FSM enters HOLD.
  - Asserting reset mid-frame aborts the frame immediately; nothing is resumed after release.
- i_ready passes through a 2-flop synchronizer. Only the synchronized value is used, so acknowledge latency is 2 to 3 cycles.
- FSM states: HOLD, IDLE, SHIFT, WAIT_ACK.
- HOLD:
  - Counts RESET_HOLD cycles after reset release with o_resetbAll low.
  - On the cycle the count completes, o_resetbAll goes high and the FSM goes to IDLE.
  - o_resetbAll then stays high until the next reset.
- IDLE:
  - o_sclk=0, o_sdout=0, o_busy=0.
  - When i_start=1, i_data is latched into a shift register with a leading start bit '1' prepended (FRAME_W+1 bits total). The FSM goes to SHIFT on the next edge.
- SHIFT:
  - Each bit occupies 2*SCLK_DIV cycles: SCLK_DIV cycles with o_sclk=0, then SCLK_DIV cycles with o_sclk=1.
  - o_sdout is updated only while o_sclk is low and is stable across each rising edge of o_sclk. The backend samples on that rising edge.
  - The first bit appears on o_sdout in the first SHIFT cycle.
  - Total SHIFT duration is exactly 2*SCLK_DIV*(FRAME_W+1) cycles, giving exactly FRAME_W+1 rising edges on o_sclk.
  - After the last high phase: o_sclk=0, o_sdout=0, and the FSM goes to WAIT_ACK.
- WAIT_ACK:
  - If synchronized ready=1: pulse o_done for one cycle and go to IDLE.
  - If ACK_TIMEOUT cycles elapse without ready: pulse o_err for one cycle and go to IDLE.
  - If ready and timeout occur in the same cycle, ready wins (o_done, no o_err).
  - If ready is already high on entry, o_done is issued in the first WAIT_ACK cycle.
- i_start is ignored in HOLD, SHIFT and WAIT_ACK. It is not queued.
- i_start in the same cycle that WAIT_ACK returns to IDLE is ignored.
- i_data may change freely after its value is latched.
- o_done and o_err are never high together.
- Bit counter width is clog2(FRAME_W+2). The divider counter is clog2(SCLK_DIV+1). Neither counter wraps except under FSM control.

Test Plan:
1. Reset release with RESET_HOLD=16 → o_resetbAll goes low→high exactly 16 cycles after i_resetbFPGA rises; o_busy=1 throughout, then 0.
2. FRAME_W=5, SCLK_DIV=2, i_data=5'b10110, i_ready tied high after reset:
   - o_sdout sampled at the o_sclk rising edges reads 1,1,0,1,1,0.
   - There are exactly 6 rising edges on o_sclk.
   - SHIFT lasts 24 cycles.
   - o_done pulses within 3 cycles of SHIFT ending.
3. i_ready held low, ACK_TIMEOUT=256 → o_err pulses exactly once, 256 cycles after entering WAIT_ACK; o_done stays 0; FSM returns to IDLE.
4. i_start pulsed mid-SHIFT with different i_data → the transmitted frame is unchanged and no second frame is sent.
5. i_resetbFPGA pulsed low in the middle of the third bit → o_sclk, o_sdout and o_resetbAll go to 0 immediately; after release, HOLD repeats for the full 16 cycles and no bits are sent until a new i_start.
6. Back-to-back: i_start issued the cycle after o_done, with i_data=5'b00001 then 5'b11111 → two complete frames, each with a correct start bit and payload; o_sclk idles low between frames.
